// File: rtl/ibus_mem_responder.sv
// iBus responder: word-addressed instruction memory answering fetches after a fixed LATENCY.
// Optional random acceptance stalls are enabled by defining IBUS_RESP_STALL_EN.
module ibus_mem_responder #(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ID_W      = 16,
    parameter int unsigned MEM_LOG2  = 10,
    parameter int unsigned LATENCY   = 2,
    parameter              INIT_FILE = ""
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_payload_address,
    input  logic [ID_W-1:0]     cmd_payload_id,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    output logic [ID_W-1:0]     rsp_id,
    output logic                rsp_error,
    input  logic                flush,
    input  logic                load_valid,
    input  logic [MEM_LOG2-1:0] load_addr,
    input  logic [DATA_W-1:0]   load_data
);

    localparam int unsigned DEPTH = 1 << MEM_LOG2;

    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $error("ibus_mem_responder: LATENCY must be within 1..8");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic                ready_q;
    logic                accept;
    logic                addr_err;
    logic [MEM_LOG2-1:0] word_idx;

    logic                st_v    [LATENCY];
    logic [ID_W-1:0]     st_id   [LATENCY];
    logic [DATA_W-1:0]   st_data [LATENCY];
    logic                st_err  [LATENCY];

`ifdef IBUS_RESP_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign cmd_ready = ready_q & (lfsr[1:0] != 2'b00);
`else
    assign cmd_ready = ready_q;
`endif

    assign accept   = cmd_valid & cmd_ready;
    assign word_idx = cmd_payload_address[MEM_LOG2+2:3];
    assign addr_err = (|cmd_payload_address[2:0]) |
                      (|cmd_payload_address[ADDR_W-1:MEM_LOG2+3]);

    // Read-before-write falls out of the non-blocking write racing the stage-0 read.
    always_ff @(posedge clock) begin
        if (load_valid) begin
            mem[load_addr] <= load_data;
        end
    end

    // Payload registers only load when a live entry moves in, so the last stage
    // (the rsp_* outputs) holds its value whenever rsp_valid is low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                st_v[i]    <= 1'b0;
                st_id[i]   <= '0;
                st_data[i] <= '0;
                st_err[i]  <= 1'b0;
            end
        end else begin
            ready_q <= 1'b1;
            st_v[0] <= accept & ~flush;
            if (accept && !flush) begin
                st_id[0]   <= cmd_payload_id;
                st_err[0]  <= addr_err;
                st_data[0] <= addr_err ? '0 : mem[word_idx];
            end
            for (int unsigned i = 1; i < LATENCY; i++) begin
                st_v[i] <= st_v[i-1] & ~flush;
                if (st_v[i-1] && !flush) begin
                    st_id[i]   <= st_id[i-1];
                    st_err[i]  <= st_err[i-1];
                    st_data[i] <= st_data[i-1];
                end
            end
        end
    end

    assign rsp_valid = st_v[LATENCY-1];
    assign rsp_id    = st_id[LATENCY-1];
    assign rsp_data  = st_data[LATENCY-1];
    assign rsp_error = st_err[LATENCY-1];

endmodule
